// File: rtl/instr_decode_reg.sv
// Decode/latch stage ahead of control_unit: registers a one-hot opcode and the operand field,
// and holds the branch-condition flag register.
module instr_decode_reg #(
  parameter int INSTR_W = 32,
  parameter int OPC_W   = 5,
  parameter int NUM_OPS = 27,
  parameter int FLAG_W  = 4,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [INSTR_W-1:0]       instr_in,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     flag_we,
  input  logic [FLAG_W-1:0]        flag_in,
  output logic                     dec_valid,
  output logic [NUM_OPS-1:0]       opcode_onehot,
  output logic [INSTR_W-OPC_W-1:0] operand_out,
  output logic                     illegal_op,
  output logic [FLAG_W-1:0]        break_flag,
  output logic [CNT_W-1:0]         dec_count
);

  localparam int OPR_W = INSTR_W - OPC_W;

  // Handshake: a word transfers on a rising edge where instr_valid & instr_ready & !flush.
  // instr_ready never looks at instr_valid, and a flush cycle swallows any offered word.
  logic             accept;
  logic [OPC_W-1:0] opc;
  logic             opc_legal;
  logic [NUM_OPS-1:0] onehot_d;

  assign opc         = instr_in[INSTR_W-1 -: OPC_W];
  assign instr_ready = !dec_valid || !stall;
  assign accept      = instr_valid && instr_ready && !flush;

  // Comparator-per-bit decode keeps the index in range; illegal opcodes yield all-zero.
  always_comb begin
    onehot_d  = '0;
    opc_legal = 1'b0;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (opc == OPC_W'(i)) begin
        onehot_d[i] = 1'b1;
        opc_legal   = 1'b1;
      end
    end
  end

  // Flags update on their own enable so a branch accepted on the same edge sees the new value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      break_flag <= '0;
    end else if (flag_we) begin
      break_flag <= flag_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_valid     <= 1'b0;
      opcode_onehot <= '0;
      operand_out   <= '0;
      illegal_op    <= 1'b0;
      dec_count     <= '0;
    end else if (flush) begin
      dec_valid     <= 1'b0;
      opcode_onehot <= '0;
      illegal_op    <= 1'b0;
    end else if (accept) begin
      dec_valid     <= 1'b1;
      opcode_onehot <= onehot_d;
      operand_out   <= instr_in[OPR_W-1:0];
      illegal_op    <= !opc_legal;
      dec_count     <= dec_count + CNT_W'(1);
    end else if (!stall) begin
      // Drain: operand_out is left alone, it is only meaningful while dec_valid=1.
      dec_valid     <= 1'b0;
      opcode_onehot <= '0;
      illegal_op    <= 1'b0;
    end
  end

endmodule
